// File: rtl/mem_access_unit.sv
// Multi-cycle memory access unit: selects address and write data, runs one word
// access per request with a programmable RAM latency, and flags rejected accesses.
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic [2:0]        MemDst,
  input  logic [1:0]        MemSrc,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] sp_in,
  input  logic [DATA_W-1:0] ze_imm,
  input  logic [DATA_W-1:0] ls_imm,
  input  logic [DATA_W-1:0] MaryData,
  input  logic [DATA_W-1:0] ShelleyData,
  input  logic [DATA_W-1:0] RAData,
  output logic              MemBusy,
  output logic              MemAck,
  output logic              MemErr,
  output logic [DATA_W-1:0] mem_out,
  output logic [1:0]        dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [AW-1:0]     cap_idx;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_write;
  logic              cap_err;

  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_err;
  logic              commit;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_comb begin
    req_addr = '0;
    case (MemDst)
      3'b000:  req_addr = pc;
      3'b001:  req_addr = ze_imm;
      3'b010:  req_addr = MaryData;
      3'b011:  req_addr = ShelleyData;
      3'b100:  req_addr = sp_in + DATA_W'(2);
      3'b101:  req_addr = sp_in + ls_imm;
      default: req_addr = '0;
    endcase
  end

  always_comb begin
    req_wdata = '0;
    case (MemSrc)
      2'b00:   req_wdata = MaryData;
      2'b01:   req_wdata = ShelleyData;
      2'b10:   req_wdata = RAData;
      default: req_wdata = '0;
    endcase
  end

  always_comb begin
    req_err = req_addr[0]
            | ({1'b0, req_addr[DATA_W-1:1]} >= DEPTH_W)
            | (MemDst[2:1] == 2'b11)
            | (MemWrite && (MemSrc == 2'b11));
  end

  // Handshake: MemReq is sampled only in IDLE and is never queued; MemBusy covers
  // capture through ack, MemAck pulses for one cycle, and MemErr is valid only with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      mem_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemReq) begin
            cap_idx   <= req_addr[AW:1];
            cap_wdata <= req_wdata;
            cap_write <= MemWrite;
            cap_err   <= req_err;
            cnt       <= LAT_M1;
            state     <= req_err ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (!cap_write) mem_out <= mem[cap_idx];
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Rejected accesses never reach WAIT, so only good writes commit here.
  assign commit = (state == WAIT) && (cnt == 4'd0) && cap_write;

  always_ff @(posedge clock) begin
    if (commit) mem[cap_idx] <= cap_wdata;
  end

  assign MemBusy   = (state != IDLE);
  assign MemAck    = (state == DONE);
  assign MemErr    = (state == DONE) && cap_err;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=16, DEPTH=1024, LATENCY=2) with
// hand-computed expectations checked by immediate assertions.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        MemReq;
  logic        MemWrite;
  logic [2:0]  MemDst;
  logic [1:0]  MemSrc;
  logic [15:0] pc, sp_in, ze_imm, ls_imm;
  logic [15:0] MaryData, ShelleyData, RAData;
  logic        MemBusy, MemAck, MemErr;
  logic [15:0] mem_out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int passed = 0;

  mem_access_unit #(.DATA_W(16), .DEPTH(1024), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
    .MemDst(MemDst), .MemSrc(MemSrc), .pc(pc), .sp_in(sp_in),
    .ze_imm(ze_imm), .ls_imm(ls_imm), .MaryData(MaryData),
    .ShelleyData(ShelleyData), .RAData(RAData), .MemBusy(MemBusy),
    .MemAck(MemAck), .MemErr(MemErr), .mem_out(mem_out), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One request: drive at a negedge, capture on the next posedge, then count
  // negedges until MemAck (bounded) and check latency, error flag and data.
  task automatic access(input logic w, input logic [2:0] dst, input logic [1:0] src,
                        input int exp_n, input logic exp_err, input logic [15:0] exp_out,
                        input string tag);
    int n;
    @(negedge clock);
    MemReq = 1'b1; MemWrite = w; MemDst = dst; MemSrc = src;
    @(posedge clock);
    #1;
    MemReq = 1'b0;
    MaryData = ~MaryData; ShelleyData = ~ShelleyData; RAData = ~RAData;
    ze_imm = ~ze_imm; sp_in = ~sp_in; pc = ~pc; ls_imm = ~ls_imm;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) check({tag, "_busy"}, 32'(MemBusy), 32'd1);
    end while (!MemAck && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(exp_n));
    check({tag, "_err"}, 32'(MemErr), 32'(exp_err));
    check({tag, "_out"}, 32'(mem_out), 32'(exp_out));
    @(negedge clock);
    check({tag, "_ackdrop"}, {30'd0, MemAck, MemBusy}, 32'd0);
  endtask

  initial begin
    int acks, doubles;
    logic prev_ack;
    MemReq = 0; MemWrite = 0; MemDst = 0; MemSrc = 0;
    pc = 0; sp_in = 0; ze_imm = 0; ls_imm = 0;
    MaryData = 0; ShelleyData = 0; RAData = 0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_outs", {13'd0, MemBusy, MemAck, MemErr, mem_out}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;

    ze_imm = 16'h0010; MaryData = 16'hBEEF;
    access(1'b1, 3'b001, 2'b00, 3, 1'b0, 16'h0000, "wr_ze");
    ze_imm = 16'h0010;
    access(1'b0, 3'b001, 2'b00, 3, 1'b0, 16'hBEEF, "rd_ze");

    sp_in = 16'h00FE; RAData = 16'h1234;
    access(1'b1, 3'b100, 2'b10, 3, 1'b0, 16'hBEEF, "wr_sp2");
    MaryData = 16'h0100;
    access(1'b0, 3'b010, 2'b00, 3, 1'b0, 16'h1234, "rd_mary");

    sp_in = 16'h0010; ls_imm = 16'h0003;
    access(1'b0, 3'b101, 2'b00, 1, 1'b1, 16'h1234, "misalign");
    ShelleyData = 16'h0800;
    access(1'b0, 3'b011, 2'b00, 1, 1'b1, 16'h1234, "oor");
    access(1'b0, 3'b110, 2'b00, 1, 1'b1, 16'h1234, "bad_dst");
    ze_imm = 16'h0010; MaryData = 16'hFFFF;
    access(1'b1, 3'b001, 2'b11, 1, 1'b1, 16'h1234, "bad_src");
    ze_imm = 16'h0010;
    access(1'b0, 3'b001, 2'b00, 3, 1'b0, 16'hBEEF, "rd_unchanged");

    sp_in = 16'hFFFE; MaryData = 16'h5A5A;
    access(1'b1, 3'b100, 2'b00, 3, 1'b0, 16'hBEEF, "wr_wrap");
    pc = 16'h0000;
    access(1'b0, 3'b000, 2'b00, 3, 1'b0, 16'h5A5A, "rd_wrap");

    ShelleyData = 16'h07FE; RAData = 16'h7777;
    access(1'b1, 3'b011, 2'b10, 3, 1'b0, 16'h5A5A, "wr_top");
    pc = 16'h07FE;
    access(1'b0, 3'b000, 2'b00, 3, 1'b0, 16'h7777, "rd_top");

    // MemReq held high: one acceptance every 4 cycles, single-cycle acks
    @(negedge clock);
    ze_imm = 16'h0010; MemDst = 3'b001; MemWrite = 1'b0; MemReq = 1'b1;
    acks = 0; doubles = 0; prev_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (MemAck) acks++;
      if (MemAck && prev_ack) doubles++;
      prev_ack = MemAck;
    end
    MemReq = 1'b0;
    check("held_acks", 32'(acks), 32'd4);
    check("held_doubles", 32'(doubles), 32'd0);
    check("held_out", 32'(mem_out), 32'h0000BEEF);
    repeat (3) @(negedge clock);

    ze_imm = 16'h0020; MaryData = 16'h1111;
    access(1'b1, 3'b001, 2'b00, 3, 1'b0, 16'hBEEF, "wr_pre");

    // reset one cycle into a write to the same word
    @(negedge clock);
    ze_imm = 16'h0020; MaryData = 16'h2222; MemDst = 3'b001; MemSrc = 2'b00;
    MemWrite = 1'b1; MemReq = 1'b1;
    @(posedge clock);
    #1 MemReq = 1'b0;
    @(negedge clock);
    check("abort_busy_pre", 32'(MemBusy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_outs", {13'd0, MemBusy, MemAck, MemErr, mem_out}, 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    ze_imm = 16'h0020;
    access(1'b0, 3'b001, 2'b00, 3, 1'b0, 16'h1111, "rd_after_abort");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
